// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage; stalls ID/EX until the result is ready.
// Optional single-cycle multiplier when MULDIV_FAST_MUL_EN is defined (divides stay iterative).
//
//  state | meaning
//  IDLE  | waiting for start; decodes special cases and loads operands
//  CALC  | one shift-add / shift-subtract step per edge, counter XLEN..1
//  DONE  | done pulse; result/rd_out valid; always returns to IDLE
module ex_muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state, state_n;
    logic [2:0]        f3_q;
    logic [4:0]        rd_q;
    logic [XLEN-1:0]   hi_q, lo_q, mag_q;
    logic              neg_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              a_signed, b_signed, a_neg, b_neg, neg_in;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              is_div, div_zero, div_ovf, fast_mul, early;
    logic [XLEN-1:0]   early_res;
    logic              accept, last_step;

    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b100, 3'b110: begin a_signed = 1'b1; b_signed = 1'b1; end
            3'b010:                         a_signed = 1'b1;
            default: ;
        endcase
    end

    assign a_neg  = a_signed & op_a[XLEN-1];
    assign b_neg  = b_signed & op_b[XLEN-1];
    assign a_mag  = a_neg ? -op_a : op_a;
    assign b_mag  = b_neg ? -op_b : op_b;
    // Remainder follows the dividend; product and quotient follow the sign product.
    assign neg_in = (funct3[2] & funct3[1]) ? a_neg : (a_neg ^ b_neg);

    assign is_div   = funct3[2];
    assign div_zero = is_div & (op_b == '0);
    assign div_ovf  = is_div & ~funct3[0] & (op_a == {1'b1, {(XLEN-1){1'b0}}}) & (op_b == '1);

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod, fast_prod_c;
    assign fast_mul    = ~funct3[2];
    assign fast_prod   = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
    assign fast_prod_c = neg_in ? -fast_prod : fast_prod;
`else
    assign fast_mul = 1'b0;
`endif

    always_comb begin
        early_res = '0;
        if (div_zero)
            early_res = funct3[1] ? op_a : '1;
        else if (div_ovf)
            early_res = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
`ifdef MULDIV_FAST_MUL_EN
        else if (fast_mul)
            early_res = (funct3[1:0] == 2'b00) ? fast_prod_c[XLEN-1:0] : fast_prod_c[2*XLEN-1:XLEN];
`endif
    end

    assign early     = div_zero | div_ovf | fast_mul;
    assign accept    = (state == IDLE) & start & ~flush;
    assign last_step = (cnt_q == CNT_W'(1));

    // One iteration of the datapath, shared between multiply and divide.
    logic [XLEN:0]     mul_sum, div_shift;
    logic [XLEN-1:0]   div_diff, hi_n, lo_n;
    logic              div_ge;

    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_q} : '0);
        div_shift = {hi_q, lo_q[XLEN-1]};
        div_ge    = (div_shift >= {1'b0, mag_q});
        div_diff  = div_shift[XLEN-1:0] - mag_q;
        if (f3_q[2]) begin
            hi_n = div_ge ? div_diff : div_shift[XLEN-1:0];
            lo_n = {lo_q[XLEN-2:0], div_ge};
        end else begin
            hi_n = mul_sum[XLEN:1];
            lo_n = {mul_sum[0], lo_q[XLEN-1:1]};
        end
    end

    logic [2*XLEN-1:0] prod_c;
    logic [XLEN-1:0]   quo_c, rem_c, final_res;

    always_comb begin
        prod_c = neg_q ? -{hi_n, lo_n} : {hi_n, lo_n};
        quo_c  = neg_q ? -lo_n : lo_n;
        rem_c  = neg_q ? -hi_n : hi_n;
        if (f3_q[2])
            final_res = f3_q[1] ? rem_c : quo_c;
        else
            final_res = (f3_q[1:0] == 2'b00) ? prod_c[XLEN-1:0] : prod_c[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        stall   = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE: if (accept) begin
                stall   = 1'b1;
                state_n = early ? DONE : CALC;
            end
            CALC: begin
                stall = 1'b1;
                if (last_step) state_n = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (flush) state_n = IDLE;
        if (reset) begin
            stall = 1'b0;
            done  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            f3_q   <= '0;
            rd_q   <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            mag_q  <= '0;
            neg_q  <= 1'b0;
            cnt_q  <= '0;
            result <= '0;
            rd_out <= '0;
        end else if (accept) begin
            f3_q  <= funct3;
            rd_q  <= rd_in;
            neg_q <= neg_in;
            hi_q  <= '0;
            lo_q  <= is_div ? a_mag : b_mag;
            mag_q <= is_div ? b_mag : a_mag;
            cnt_q <= CNT_W'(XLEN);
            if (early) begin
                result <= early_res;
                rd_out <= rd_in;
            end
        end else if (state == CALC && !flush) begin
            hi_q  <= hi_n;
            lo_q  <= lo_n;
            cnt_q <= cnt_q - CNT_W'(1);
            if (last_step) begin
                result <= final_res;
                rd_out <= rd_q;
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed-vector bench for ex_muldiv_unit: table of operations plus flush, reset and back-to-back sequences.
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset, start, flush;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b;
    logic [4:0]  rd_in;
    logic        stall, done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int n_checks = 0;
    int n_fail   = 0;

    localparam int IT = 33;
`ifdef MULDIV_FAST_MUL_EN
    localparam int ML = 1;
`else
    localparam int ML = 33;
`endif

    localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011;
    localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

    ex_muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .flush  (flush),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .rd_in  (rd_in),
        .stall  (stall),
        .done   (done),
        .result (result),
        .rd_out (rd_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
        string       name;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] r);
        funct3 = f;
        op_a   = a;
        op_b   = b;
        rd_in  = r;
        start  = 1'b1;
    endtask

    // Counts edges from the start edge until done; afterwards crosses the DONE edge with start still high.
    task automatic wait_done(input logic [31:0] exp, input logic [4:0] exp_rd, input int exp_lat, input string name);
        int cyc = 0;
        bit got = 0;
        bit stall_ok = 1;
        while (!got && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) got = 1;
            else if (!stall) stall_ok = 0;
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: no done after %0d cycles, expected done after %0d", name, cyc, exp_lat);
            return;
        end
        check({name, "_latency"}, 32'(cyc), 32'(exp_lat));
        check({name, "_result"}, result, exp);
        check({name, "_rd"}, {27'd0, rd_out}, {27'd0, exp_rd});
        check({name, "_stall_done"}, {31'd0, stall}, 32'd0);
        check({name, "_stall_held"}, {31'd0, stall_ok}, 32'd1);
        @(posedge clk);
        #1;
        check({name, "_single_done"}, {31'd0, done}, 32'd0);
    endtask

    task automatic expect_quiet(input int n, input string name);
        bit seen = 0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (done) seen = 1;
        end
        check({name, "_no_done"}, {31'd0, seen}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{F_DIV,    32'hFFFFFFF9, 32'h00000002, 5'd5,  32'hFFFFFFFD, IT, "div_m7_2"};
        vecs[1]  = '{F_REM,    32'hFFFFFFF9, 32'h00000002, 5'd5,  32'hFFFFFFFF, IT, "rem_m7_2"};
        vecs[2]  = '{F_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFF, ML, "mulhsu_ff"};
        vecs[3]  = '{F_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'hFFFFFFFE, ML, "mulhu_ff"};
        vecs[4]  = '{F_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,  32'h00000001, ML, "mul_ff"};
        vecs[5]  = '{F_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 5'd9,  32'h00000000, ML, "mulh_ff"};
        vecs[6]  = '{F_MULH,   32'h80000000, 32'h80000000, 5'd10, 32'h40000000, ML, "mulh_min"};
        vecs[7]  = '{F_MUL,    32'h12345678, 32'h00000010, 5'd11, 32'h23456780, ML, "mul_shift"};
        vecs[8]  = '{F_MUL,    32'hFFFFFFFD, 32'h00000004, 5'd12, 32'hFFFFFFF4, ML, "mul_neg"};
        vecs[9]  = '{F_MULH,   32'hFFFFFFFD, 32'h00000004, 5'd13, 32'hFFFFFFFF, ML, "mulh_neg"};
        vecs[10] = '{F_DIVU,   32'h00000064, 32'h00000000, 5'd14, 32'hFFFFFFFF, 1,  "divu_by0"};
        vecs[11] = '{F_REMU,   32'h12345678, 32'h00000000, 5'd15, 32'h12345678, 1,  "remu_by0"};
        vecs[12] = '{F_DIV,    32'h00000064, 32'h00000000, 5'd16, 32'hFFFFFFFF, 1,  "div_by0"};
        vecs[13] = '{F_REM,    32'hFFFFFFFB, 32'h00000000, 5'd17, 32'hFFFFFFFB, 1,  "rem_by0"};
        vecs[14] = '{F_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd18, 32'h80000000, 1,  "div_ovf"};
        vecs[15] = '{F_REM,    32'h80000000, 32'hFFFFFFFF, 5'd19, 32'h00000000, 1,  "rem_ovf"};
        vecs[16] = '{F_DIVU,   32'h00000064, 32'h00000007, 5'd20, 32'h0000000E, IT, "divu_100_7"};
        vecs[17] = '{F_DIV,    32'h00000007, 32'hFFFFFFFE, 5'd21, 32'hFFFFFFFD, IT, "div_7_m2"};
        vecs[18] = '{F_REM,    32'h00000007, 32'hFFFFFFFE, 5'd22, 32'h00000001, IT, "rem_7_m2"};
        vecs[19] = '{F_REM,    32'hFFFFFFF9, 32'hFFFFFFFE, 5'd23, 32'hFFFFFFFF, IT, "rem_m7_m2"};
        vecs[20] = '{F_DIVU,   32'h80000000, 32'hFFFFFFFF, 5'd24, 32'h00000000, IT, "divu_big"};
        vecs[21] = '{F_REMU,   32'h80000000, 32'hFFFFFFFF, 5'd25, 32'h80000000, IT, "remu_big"};

        reset  = 1'b1;
        start  = 1'b1;
        flush  = 1'b0;
        funct3 = F_DIV;
        op_a   = 32'h1;
        op_b   = 32'h1;
        rd_in  = 5'd1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_stall",  {31'd0, stall}, 32'd0);
        check("reset_done",   {31'd0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_rd",     {27'd0, rd_out}, 32'd0);
        reset = 1'b0;
        start = 1'b0;
        #1;
        check("idle_stall", {31'd0, stall}, 32'd0);

        for (int i = 0; i < NV; i++) begin
            issue(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd);
            wait_done(vecs[i].exp, vecs[i].rd, vecs[i].lat, vecs[i].name);
            start = 1'b0;
        end

        // Flush during the tenth divide iteration: no done, outputs keep the previous result.
        issue(F_DIVU, 32'd100, 32'd7, 5'd9);
        @(posedge clk);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        start = 1'b0;
        #1;
        check("flush_stall", {31'd0, stall}, 32'd0);
        check("flush_done",  {31'd0, done}, 32'd0);
        expect_quiet(40, "flush");
        check("flush_result_hold", result, 32'h80000000);
        check("flush_rd_hold", {27'd0, rd_out}, 32'd25);
        issue(F_REMU, 32'd100, 32'd7, 5'd26);
        wait_done(32'd2, 5'd26, IT, "remu_after_flush");
        start = 1'b0;

        // Flush has priority over start in IDLE.
        issue(F_DIVU, 32'd100, 32'd0, 5'd27);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        start = 1'b0;
        expect_quiet(3, "flush_vs_start");
        check("flush_vs_start_result", result, 32'd2);

        // Back-to-back multiplies with start held through the DONE edge.
        issue(F_MUL, 32'd3, 32'd4, 5'd3);
        wait_done(32'd12, 5'd3, ML, "mul_3x4");
        issue(F_MUL, 32'd5, 32'd6, 5'd4);
        wait_done(32'd30, 5'd4, ML, "mul_5x6");
        start = 1'b0;

        // Reset in the middle of a divide aborts without a done pulse.
        issue(F_DIV, 32'd1000, 32'd3, 5'd7);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        #1;
        check("midreset_stall",  {31'd0, stall}, 32'd0);
        check("midreset_result", result, 32'd0);
        check("midreset_rd",     {27'd0, rd_out}, 32'd0);
        expect_quiet(40, "midreset");

        issue(F_DIV, 32'd1000, 32'd3, 5'd7);
        wait_done(32'd333, 5'd7, IT, "div_after_reset");
        start = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
Iterative RV32M multiply/divide unit in the EX stage, consuming the operand, funct3 and rd outputs of the ID/EX pipeline register. It runs MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over multiple cycles and drives `stall` to hold the ID/EX register (write = ~stall) until the result is ready. On completion it presents `result`/`rd_out` for one cycle, in parallel with the ALU result path into EX/MEM.

Parameters:
XLEN, 32, operand/result width; only 32 is supported.
CNT_W, 6, iteration counter width; must hold value XLEN.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  ID/EX holds a valid M-extension R-type instruction (decoded upstream)
flush  input  1  synchronous abort of the current operation (branch/exception kill)
funct3  input  3  operation select (RV32M encoding)
op_a  input  32  rs1 value (forwarded)
op_b  input  32  rs2 value (forwarded)
rd_in  input  5  destination register
stall  output  1  hold ID/EX and upstream stages
done  output  1  one-cycle pulse: result valid
result  output  32  operation result
rd_out  output  5  destination of completed operation

Behaviour:
- Reset values: state=IDLE, stall=0, done=0, result=0, rd_out=0, counter=0, internal accumulators=0.
- FSM states: IDLE, CALC, DONE.
- IDLE: if start=1 and flush=0, latch funct3, rd_in, operand magnitudes and sign flags. Go to CALC, or go directly to DONE for a special case.
- CALC: one shift-add (multiply) or restoring shift-subtract (divide) step per edge. Counter runs XLEN..1. Go to DONE on the edge that completes step 32.
- DONE: done=1, result/rd_out valid. Next state is always IDLE. start is ignored in DONE, because the same instruction is still visible in ID/EX.
- stall: combinational. stall = (state==IDLE & start & ~flush) | state==CALC. stall=0 in DONE, so the pipeline advances on the DONE edge.
- Latency: if start is sampled at edge N, done is high in the cycle after edge N+32. Special cases: done is high in the cycle after edge N.
- result/rd_out hold their last value outside DONE.
- Multiply: works on magnitudes with a 64-bit product, then applies two's-complement correction.
  - MUL: low 32 bits.
  - MULH: signed×signed, high 32 bits.
  - MULHSU: op_a signed, op_b unsigned.
  - MULHU: unsigned×unsigned.
- Divide: restoring divide on magnitudes.
  - DIV: quotient negated when operand signs differ.
  - REM: remainder takes the sign of the dividend.
  - DIVU/REMU: unsigned.
- Special cases (go directly to DONE):
  - Divide by zero: DIV/DIVU result=0xFFFFFFFF; REM/REMU result=op_a.
  - Signed overflow (op_a=0x80000000, op_b=0xFFFFFFFF): DIV result=0x80000000; REM result=0.
- flush: in any state, next state=IDLE with no done pulse; result/rd_out unchanged. flush has priority over start.
- reset mid-operation: behaves as full reset; no done pulse.
- start held high across the DONE→IDLE transition with a new instruction starts a new operation normally.

Optional Feature:
MULDIV_FAST_MUL_EN
- Defined: MUL/MULH/MULHSU/MULHU use a single-cycle 64-bit combinational multiply. IDLE→DONE directly, so done is high in the cycle after the start edge. stall is high only during the start cycle.
- Undefined: all multiplies use the 32-step iterative path. Divides are always iterative.

Test Plan:
- reset=1 for 2 cycles with start=1 → stall=0, done=0, result=0, rd_out=0, state IDLE.
- DIV op_a=-7 (0xFFFFFFF9), op_b=2, rd_in=5, start at edge N → stall high until done. done high in exactly one cycle after edge N+32; result=0xFFFFFFFD (−3), rd_out=5. REM with the same operands → 0xFFFFFFFF (−1).
- MULHSU op_a=0xFFFFFFFF, op_b=0xFFFFFFFF → result=0xFFFFFFFF. MULHU same operands → 0xFFFFFFFE. MUL → 0x00000001. Latency is 33 edges, or 1 edge with MULDIV_FAST_MUL_EN.
- DIVU op_b=0 → done the cycle after start, result=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF → result=0x80000000 with 1-edge latency.
- Start DIVU 100/7, assert flush at CALC iteration 10 → IDLE next cycle, no done pulse, stall low. A new REMU 100/7 started next → result=2.
- Back-to-back: MUL 3×4, then start held high for MUL 5×6 immediately after DONE → two done pulses, results 12 then 30. No done on the DONE-cycle start.
